// File: rtl/axi_rd_arb_if.sv
// Bundled AR/R signals between the read requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface axi_rd_arb_if #(
    parameter int NUM_M = 2
);
    logic [NUM_M-1:0]    m_ar_valid;
    logic [NUM_M-1:0]    m_ar_ready;
    logic [32*NUM_M-1:0] m_ar_addr;
    logic [6*NUM_M-1:0]  m_ar_id;
    logic [8*NUM_M-1:0]  m_ar_len;
    logic [3*NUM_M-1:0]  m_ar_size;
    logic [2*NUM_M-1:0]  m_ar_burst;
    logic [NUM_M-1:0]    m_r_valid;
    logic [NUM_M-1:0]    m_r_ready;
    logic [255:0]        m_r_data;
    logic [5:0]          m_r_id;
    logic [1:0]          m_r_resp;
    logic                m_r_last;

    logic                s_ar_valid;
    logic                s_ar_ready;
    logic [31:0]         s_ar_addr;
    logic [5:0]          s_ar_id;
    logic [7:0]          s_ar_len;
    logic [2:0]          s_ar_size;
    logic [1:0]          s_ar_burst;
    logic                s_r_valid;
    logic                s_r_ready;
    logic [255:0]        s_r_data;
    logic [5:0]          s_r_id;
    logic [1:0]          s_r_resp;
    logic                s_r_last;

    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_id, m_ar_len, m_ar_size, m_ar_burst, m_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_id, m_r_resp, m_r_last,
        output s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_r_ready,
        input  s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_resp, s_r_last
    );

    modport master (
        output m_ar_valid, m_ar_addr, m_ar_id, m_ar_len, m_ar_size, m_ar_burst, m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_id, m_r_resp, m_r_last,
        input  s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_r_ready,
        output s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_resp, s_r_last
    );
endinterface

// File: rtl/axi_rd_arb.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_M requesters, one burst in flight.
// Optional AXI_RD_ARB_LENCHK_EN builds a beat counter that flags a sticky burst-length error.
module axi_rd_arb #(
    parameter int NUM_M = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             resetn,
    axi_rd_arb_if.slave      bus,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             lenchk_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_grant;
    logic             r_busy;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    int               w_idx;
    int               w_sel;
    logic             w_in_addr;
    logic             w_in_data;
    logic             w_r_hs;
    logic [IDX_W-1:0] w_next_ptr;

    assign w_in_addr  = (r_state == ADDR);
    assign w_in_data  = (r_state == DATA);
    assign w_sel      = int'(r_grant);
    assign w_r_hs     = w_in_data & bus.s_r_valid & bus.m_r_ready[r_grant];
    assign w_next_ptr = (r_grant == IDX_W'(NUM_M - 1)) ? '0 : r_grant + IDX_W'(1);

    // First valid requester scanning upward from the pointer, wrapping at NUM_M.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_M; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_M) w_idx = w_idx - NUM_M;
            if (!w_found && bus.m_ar_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_grant <= w_pick;
                    r_state <= ADDR;
                    r_busy  <= 1'b1;
                end
                ADDR: if (bus.s_ar_ready) begin
                    r_state  <= DATA;
                    r_rr_ptr <= w_next_ptr;
                end
                DATA: if (w_r_hs && bus.s_r_last) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_idx = r_grant;
    assign busy      = r_busy;

    always_comb begin
        bus.s_ar_valid = w_in_addr;
        bus.s_ar_addr  = '0;
        bus.s_ar_id    = '0;
        bus.s_ar_len   = '0;
        bus.s_ar_size  = '0;
        bus.s_ar_burst = '0;
        if (w_in_addr) begin
            bus.s_ar_addr  = bus.m_ar_addr[w_sel*32 +: 32];
            bus.s_ar_id    = bus.m_ar_id[w_sel*6 +: 6];
            bus.s_ar_len   = bus.m_ar_len[w_sel*8 +: 8];
            bus.s_ar_size  = bus.m_ar_size[w_sel*3 +: 3];
            bus.s_ar_burst = bus.m_ar_burst[w_sel*2 +: 2];
        end
    end

    // R payload is only forwarded while a burst owns the port, so it reads zero otherwise.
    always_comb begin
        bus.s_r_ready = w_in_data & bus.m_r_ready[r_grant];
        bus.m_r_data  = '0;
        bus.m_r_id    = '0;
        bus.m_r_resp  = '0;
        bus.m_r_last  = 1'b0;
        if (w_in_data) begin
            bus.m_r_data = bus.s_r_data;
            bus.m_r_id   = bus.s_r_id;
            bus.m_r_resp = bus.s_r_resp;
            bus.m_r_last = bus.s_r_last;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : g_port
            assign bus.m_ar_ready[gi] = w_in_addr && (r_grant == IDX_W'(gi)) && bus.s_ar_ready;
            assign bus.m_r_valid[gi]  = w_in_data && (r_grant == IDX_W'(gi)) && bus.s_r_valid;
        end
    endgenerate

`ifdef AXI_RD_ARB_LENCHK_EN
    logic [7:0] r_beat_cnt;
    logic       r_lenchk_err;

    // Counter holds beats remaining after the current one; last must coincide with zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_beat_cnt   <= '0;
            r_lenchk_err <= 1'b0;
        end else if (w_in_addr && bus.s_ar_ready) begin
            r_beat_cnt <= bus.s_ar_len;
        end else if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt - 8'd1;
            if (bus.s_r_last != (r_beat_cnt == 8'd0)) r_lenchk_err <= 1'b1;
        end
    end

    assign lenchk_err = r_lenchk_err;
`else
    assign lenchk_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed plus randomized bench for axi_rd_arb with four requesters and a simple memory model.
// Grant order comes from a round-robin pick over the bench's own pending-request mask.
module tb_axi_rd_arb;
    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          lenchk_err;

    int checks = 0;
    int errors = 0;

    axi_rd_arb_if #(.NUM_M(N)) bus ();

    axi_rd_arb #(.NUM_M(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .lenchk_err (lenchk_err)
    );

    always #5 clk = ~clk;

    logic [31:0] req_addr [N];
    logic [5:0]  req_id   [N];
    logic [7:0]  req_len  [N];
    logic [2:0]  req_size [N];
    logic [1:0]  req_burst[N];
    logic [N-1:0] pend = '0;
    int           ref_ptr = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [255:0] pat(input logic [31:0] addr, input int beat);
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[k*32 +: 32] = (addr + 32'(beat * 32 + k * 4)) ^ 32'hA5A5_0000;
        return p;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic post_req(input int i, input logic [31:0] addr, input logic [7:0] len);
        req_addr[i]  = addr;
        req_id[i]    = 6'($urandom);
        req_len[i]   = len;
        req_size[i]  = 3'($urandom_range(0, 5));
        req_burst[i] = 2'($urandom_range(0, 2));
        bus.m_ar_addr[i*32 +: 32] = addr;
        bus.m_ar_id[i*6 +: 6]     = req_id[i];
        bus.m_ar_len[i*8 +: 8]    = len;
        bus.m_ar_size[i*3 +: 3]   = req_size[i];
        bus.m_ar_burst[i*2 +: 2]  = req_burst[i];
        bus.m_ar_valid[i]         = 1'b1;
        pend[i]                   = 1'b1;
    endtask

    // Plays the memory for one granted burst; rst_beat >= 0 pulls resetn during that beat.
    task automatic serve(input int g, input int beats, input int ar_dly, input bit stall, input int rst_beat);
        int t;
        int d;
        logic [N-1:0] rdy;
        t = 0;
        while (bus.s_ar_valid !== 1'b1 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        check("ar_valid_seen", bus.s_ar_valid, 1'b1);
        if (bus.s_ar_valid !== 1'b1) return;
        check("grant_idx", grant_idx, g);
        check("busy_addr", busy, 1'b1);
        check("ar_addr", bus.s_ar_addr, req_addr[g]);
        check("ar_id", bus.s_ar_id, req_id[g]);
        check("ar_len", bus.s_ar_len, req_len[g]);
        check("ar_size", bus.s_ar_size, req_size[g]);
        check("ar_burst", bus.s_ar_burst, req_burst[g]);
        check("ar_ready_wait", bus.m_ar_ready, '0);
        d = (ar_dly < 0) ? $urandom_range(0, 3) : ar_dly;
        for (int c = 0; c < d; c++) begin
            @(negedge clk);
            bus.s_r_valid = 1'($urandom_range(0, 1));
            bus.m_r_ready = '1;
            #1;
            check("r_ready_in_addr", bus.s_r_ready, 1'b0);
            check("r_valid_in_addr", bus.m_r_valid, '0);
            check("ar_addr_stable", bus.s_ar_addr, req_addr[g]);
        end
        bus.s_r_valid  = 1'b0;
        bus.s_ar_ready = 1'b1;
        #1;
        check("ar_ready_fwd", bus.m_ar_ready, onehot(g));
        @(negedge clk);
        bus.s_ar_ready    = 1'b0;
        bus.m_ar_valid[g] = 1'b0;
        pend[g]           = 1'b0;
        ref_ptr           = (g + 1) % N;
        for (int b = 0; b < beats; b++) begin
            bus.s_r_valid = 1'b1;
            bus.s_r_data  = pat(req_addr[g], b);
            bus.s_r_id    = req_id[g];
            bus.s_r_resp  = 2'(b);
            bus.s_r_last  = (b == beats - 1);
            for (int s = 0; s < 8; s++) begin
                rdy = N'($urandom);
                if (stall) rdy[g] = !(b == 1 && s < 2);
                else if (s >= 2) rdy[g] = 1'b1;
                bus.m_r_ready = rdy;
                #1;
                check("r_valid_onehot", bus.m_r_valid, onehot(g));
                check("r_ready_fwd", bus.s_r_ready, rdy[g]);
                check("r_data", bus.m_r_data, pat(req_addr[g], b));
                check("r_last", bus.m_r_last, (b == beats - 1));
                check("r_id", bus.m_r_id, req_id[g]);
                if (rst_beat == b) begin
                    resetn = 1'b0;
                    #1;
                    check("rst_busy", busy, 1'b0);
                    check("rst_grant", grant_idx, '0);
                    check("rst_r_valid", bus.m_r_valid, '0);
                    check("rst_r_ready", bus.s_r_ready, 1'b0);
                    check("rst_r_data", bus.m_r_data, '0);
                    check("rst_ar_valid", bus.s_ar_valid, 1'b0);
                    bus.s_r_valid  = 1'b0;
                    bus.s_r_last   = 1'b0;
                    bus.m_ar_valid = '0;
                    pend           = '0;
                    ref_ptr        = 0;
                    @(negedge clk);
                    resetn = 1'b1;
                    #1;
                    check("post_rst_busy", busy, 1'b0);
                    return;
                end
                if (rdy[g]) break;
                @(negedge clk);
            end
            @(negedge clk);
        end
        bus.s_r_valid = 1'b0;
        bus.s_r_last  = 1'b0;
        #1;
        check("busy_after_last", busy, 1'b0);
        check("r_valid_idle", bus.m_r_valid, '0);
        $display("burst grant=%0d addr=%08h beats=%0d", g, req_addr[g], beats);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bus.m_ar_valid = '0; bus.m_ar_addr = '0; bus.m_ar_id = '0; bus.m_ar_len = '0;
        bus.m_ar_size = '0;  bus.m_ar_burst = '0; bus.m_r_ready = '0;
        bus.s_ar_ready = 1'b0; bus.s_r_valid = 1'b0; bus.s_r_data = '0;
        bus.s_r_id = '0; bus.s_r_resp = '0; bus.s_r_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_grant", grant_idx, '0);
        check("reset_ar_valid", bus.s_ar_valid, 1'b0);
        check("reset_ar_ready", bus.m_ar_ready, '0);
        check("reset_r_valid", bus.m_r_valid, '0);
        check("reset_lenchk", lenchk_err, 1'b0);
        resetn = 1'b1;
        #1;

        // Simultaneous single-beat requests straight after reset: 0 then 1.
        post_req(0, 32'h0000_2000, 8'd0);
        post_req(1, 32'h0000_3000, 8'd0);
        serve(0, 1, 0, 1'b0, -1);
        serve(1, 1, 0, 1'b0, -1);

        // Requester 1 held while requester 0 keeps coming back: grants alternate.
        post_req(0, 32'h0000_0100, 8'd0);
        post_req(1, 32'h0000_0200, 8'd1);
        for (int j = 0; j < 4; j++) begin
            serve(j % 2, int'(req_len[j % 2]) + 1, -1, 1'b0, -1);
            if (j < 2) post_req(j % 2, 32'h0000_0400 + 32'(j * 64), 8'(j));
        end

        // Single requester, 4-beat burst.
        post_req(0, 32'h0000_1000, 8'd3);
        serve(0, 4, 0, 1'b0, -1);
        check("lenchk_normal", lenchk_err, 1'b0);

        // Slow AR acceptance plus a two-cycle requester stall mid-burst.
        post_req(0, 32'h0000_4000, 8'd3);
        serve(0, 4, 5, 1'b1, -1);

        // Reset pulsed during beat 2 of an 8-beat burst, then a fresh grant.
        post_req(3, 32'h0000_5000, 8'd7);
        serve(rr_pick(pend, ref_ptr), 8, 0, 1'b0, 1);
        post_req(2, 32'h0000_6000, 8'd1);
        serve(2, 2, 0, 1'b0, -1);

`ifdef AXI_RD_ARB_LENCHK_EN
        post_req(1, 32'h0000_7000, 8'd3);
        serve(rr_pick(pend, ref_ptr), 2, 0, 1'b0, -1);
        check("lenchk_set", lenchk_err, 1'b1);
        repeat (3) @(negedge clk);
        check("lenchk_sticky", lenchk_err, 1'b1);
`else
        check("lenchk_tied", lenchk_err, 1'b0);
`endif

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    post_req(i, $urandom & 32'hFFFF_FFE0, 8'($urandom_range(0, 3)));
            end
            if (pend == '0) begin
                g = $urandom_range(0, N - 1);
                post_req(g, $urandom & 32'hFFFF_FFE0, 8'($urandom_range(0, 3)));
            end
            g = rr_pick(pend, ref_ptr);
            serve(g, int'(req_len[g]) + 1, -1, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
